hardwired_control_sequencer: RTL and testbench

//  Hardwired control unit driving every control input of the ALU-system datapath (RF, ALU, ARF, IR, memory, MuxA/B/C).

---
 rtl/hardwired_control_sequencer_pkg.sv | 73 +++++++
 rtl/hardwired_control_sequencer_if.sv | 34 +++
 rtl/hardwired_control_sequencer_decoder.sv | 63 ++++++
 rtl/hardwired_control_sequencer.sv | 149 ++++++++++++++
 tb/tb_hardwired_control_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/hardwired_control_sequencer_pkg.sv
// ctrl_pkg: shared definitions for the hardwired control sequencer.
//   - timing-state and decoded op-class encodings
//   - opcode values, RF/ARF/ALU function codes, mux select codes
//   - the control-word struct and the IDLE / INIT words
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT, ST_T0, ST_T1, ST_T2, ST_T3, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        OC_BRA, OC_BNE, OC_LDI, OC_LDM, OC_STM, OC_INC, OC_DEC,
        OC_ALU, OC_MOV, OC_HLT, OC_ILL
    } op_class_t;

    // Opcodes (IR[15:10])
    localparam logic [5:0] OP_BRA = 6'h00, OP_BNE = 6'h01, OP_LDI = 6'h02,
                           OP_LDM = 6'h03, OP_STM = 6'h04, OP_INC = 6'h05,
                           OP_DEC = 6'h06, OP_ADD = 6'h07, OP_SUB = 6'h08,
                           OP_AND = 6'h09, OP_ORR = 6'h0A, OP_XOR = 6'h0B,
                           OP_MOV = 6'h0C, OP_HLT = 6'h3F;

    // RF / ARF function codes
    localparam logic [2:0] FUN_DEC = 3'b000, FUN_INC = 3'b001, FUN_LOAD = 3'b010,
                           FUN_CLR = 3'b011, FUN_WRLO = 3'b101, FUN_WRHI = 3'b110;

    // ALU function codes
    localparam logic [4:0] ALU_A   = 5'b10000, ALU_ADD = 5'b10100, ALU_SUB = 5'b10110,
                           ALU_AND = 5'b10111, ALU_ORR = 5'b11000, ALU_XOR = 5'b11001;

    // ARF output selects and active-low {PC,AR,SP} enables
    localparam logic [1:0] ARF_PC = 2'b00, ARF_AR = 2'b10;
    localparam logic [2:0] ARF_EN_PC = 3'b011, ARF_EN_AR = 3'b101, ARF_EN_NONE = 3'b111;

    // MuxA/MuxB sources
    localparam logic [1:0] MUX_ALU = 2'b00, MUX_MEM = 2'b10, MUX_IMM = 2'b11;

    typedef struct packed {
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = '{
        rf_outa: 3'b000, rf_outb: 3'b000, rf_fun: 3'b000,
        rf_reg: 4'b1111, rf_scr: 4'b1111,
        alu_fun: 5'b00000, alu_wf: 1'b0,
        arf_outc: 2'b00, arf_outd: 2'b00, arf_fun: 3'b000, arf_reg: 3'b111,
        ir_lh: 1'b0, ir_write: 1'b0, mem_wr: 1'b0, mem_cs: 1'b1,
        mux_a: 2'b00, mux_b: 2'b00, mux_c: 1'b0
    };

    // Active-low one-hot enable for R1..R4 (idx 00 = R1 = bit3)
    function automatic logic [3:0] reg_en_n(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/hardwired_control_sequencer_if.sv
// Datapath control interface.
//   master: the sequencer -- drives the control word and status, reads IROut/FlagsOut.
//   slave : the datapath  -- consumes the control word, supplies IROut/FlagsOut.
interface hardwired_control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  FlagsOut;      // {Z,C,N,O}
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic        Halted, IllegalOp;

    modport master (
        input  IROut, FlagsOut,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel,
               Halted, IllegalOp
    );

    modport slave (
        output IROut, FlagsOut,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel,
               Halted, IllegalOp
    );
endinterface

// File: rtl/hardwired_control_sequencer_decoder.sv
// instr_decoder: purely combinational instruction decode.
//   ir_i       : instruction register
//   class_o    : op class (OC_ILL for unknown opcode or bad Format-B field)
//   rx_sel_o   : RF read select of the Format-A register (1,RSEL)
//   rx_en_o    : active-low RF enable of the Format-A register
//   dst_en_o   : active-low RF enable of the Format-B destination
//   src1_o/src2_o : Format-B read selects
//   alu_fun_o  : ALU function for Format-B ops
//   wf_o       : Format-B S bit (flag write)
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [15:0] ir_i,
    output op_class_t   class_o,
    output logic [2:0]  rx_sel_o,
    output logic [3:0]  rx_en_o,
    output logic [3:0]  dst_en_o,
    output logic [2:0]  src1_o,
    output logic [2:0]  src2_o,
    output logic [4:0]  alu_fun_o,
    output logic        wf_o
);
    logic [OPC_W-1:0] opc;
    logic [2:0]       dst;
    logic             fmt_b_ok;

    assign opc       = ir_i[15:16-OPC_W];
    assign dst       = ir_i[8:6];
    assign src1_o    = ir_i[5:3];
    assign src2_o    = ir_i[2:0];
    assign wf_o      = ir_i[9];
    assign rx_sel_o  = {1'b1, ir_i[9:8]};
    assign rx_en_o   = reg_en_n(ir_i[9:8]);
    assign dst_en_o  = reg_en_n(dst[1:0]);
    // Format-B register fields only address R1..R4 (1xx)
    assign fmt_b_ok  = dst[2] & src1_o[2] & src2_o[2];

    always_comb begin
        class_o   = OC_ILL;
        alu_fun_o = ALU_A;
        case (6'(opc))
            OP_BRA: class_o = OC_BRA;
            OP_BNE: class_o = OC_BNE;
            OP_LDI: class_o = OC_LDI;
            OP_LDM: class_o = OC_LDM;
            OP_STM: class_o = OC_STM;
            OP_INC: class_o = OC_INC;
            OP_DEC: class_o = OC_DEC;
            OP_ADD: begin class_o = OC_ALU; alu_fun_o = ALU_ADD; end
            OP_SUB: begin class_o = OC_ALU; alu_fun_o = ALU_SUB; end
            OP_AND: begin class_o = OC_ALU; alu_fun_o = ALU_AND; end
            OP_ORR: begin class_o = OC_ALU; alu_fun_o = ALU_ORR; end
            OP_XOR: begin class_o = OC_ALU; alu_fun_o = ALU_XOR; end
            OP_MOV: class_o = OC_MOV;
            OP_HLT: class_o = OC_HLT;
            default: class_o = OC_ILL;
        endcase
        if ((class_o == OC_ALU || class_o == OC_MOV) && !fmt_b_ok)
            class_o = OC_ILL;
    end
endmodule

// File: rtl/hardwired_control_sequencer.sv
// hardwired_control_sequencer: timing-state FSM plus control-word mux for the
// ALU-system datapath. Fetches the 16-bit instruction in T0/T1 (low then high
// byte), executes in T2 (and T3 for LDM/STM), HALT is terminal until reset.
//   Clock : rising-edge clock shared with the datapath
//   Reset : asynchronous, active-low; forces INIT state and the IDLE word
//   cb    : control interface (master side)
module hardwired_control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPC_W           = 6,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                                Clock,
    input  logic                                Reset,
    hardwired_control_sequencer_if.master       cb
);
    state_t     state_q, state_d;
    ctrl_word_t cw, cw_o;
    op_class_t  oc;
    logic [2:0] rx_sel, src1, src2;
    logic [3:0] rx_en, dst_en;
    logic [4:0] alu_fun;
    logic       wf, z_flag;
    logic       unused_flags;

    assign z_flag       = cb.FlagsOut[3];
    assign unused_flags = ^cb.FlagsOut[2:0];

    instr_decoder #(.OPC_W(OPC_W)) u_dec (
        .ir_i      (cb.IROut),
        .class_o   (oc),
        .rx_sel_o  (rx_sel),
        .rx_en_o   (rx_en),
        .dst_en_o  (dst_en),
        .src1_o    (src1),
        .src2_o    (src2),
        .alu_fun_o (alu_fun),
        .wf_o      (wf)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cw      = CW_IDLE;
        case (state_q)
            ST_INIT: begin
                cw.rf_fun  = FUN_CLR;
                cw.rf_reg  = 4'b0000;
                cw.rf_scr  = 4'b0000;
                cw.arf_fun = FUN_CLR;
                cw.arf_reg = 3'b000;
                state_d    = ST_T0;
            end
            ST_T0, ST_T1: begin
                cw.arf_outd = ARF_PC;
                cw.mem_cs   = 1'b0;
                cw.ir_write = 1'b1;
                cw.ir_lh    = (state_q == ST_T1);
                cw.arf_fun  = FUN_INC;
                cw.arf_reg  = ARF_EN_PC;
                state_d     = (state_q == ST_T0) ? ST_T1 : ST_T2;
            end
            ST_T2, ST_T3: begin
                state_d = ST_T0;
                case (oc)
                    OC_BRA, OC_BNE: begin
                        // BNE with Z set leaves the word IDLE
                        if (oc == OC_BRA || !z_flag) begin
                            cw.mux_b   = MUX_IMM;
                            cw.arf_fun = FUN_LOAD;
                            cw.arf_reg = ARF_EN_PC;
                        end
                    end
                    OC_LDI: begin
                        cw.mux_a  = MUX_IMM;
                        cw.rf_fun = FUN_LOAD;
                        cw.rf_reg = rx_en;
                    end
                    OC_LDM: begin
                        cw.arf_outd = ARF_AR;
                        cw.mem_cs   = 1'b0;
                        cw.mux_a    = MUX_MEM;
                        cw.rf_fun   = (state_q == ST_T2) ? FUN_WRLO : FUN_WRHI;
                        cw.rf_reg   = rx_en;
                        cw.arf_fun  = FUN_INC;
                        cw.arf_reg  = ARF_EN_AR;
                        if (state_q == ST_T2) state_d = ST_T3;
                    end
                    OC_STM: begin
                        cw.rf_outa  = rx_sel;
                        cw.alu_fun  = ALU_A;
                        cw.arf_outd = ARF_AR;
                        cw.mem_cs   = 1'b0;
                        cw.mem_wr   = 1'b1;
                        cw.mux_c    = (state_q == ST_T3);
                        cw.arf_fun  = FUN_INC;
                        cw.arf_reg  = ARF_EN_AR;
                        if (state_q == ST_T2) state_d = ST_T3;
                    end
                    OC_INC, OC_DEC: begin
                        cw.rf_fun = (oc == OC_INC) ? FUN_INC : FUN_DEC;
                        cw.rf_reg = rx_en;
                    end
                    OC_ALU, OC_MOV: begin
                        cw.rf_outa = src1;
                        cw.rf_outb = src2;
                        cw.alu_fun = (oc == OC_MOV) ? ALU_A : alu_fun;
                        cw.alu_wf  = wf;
                        cw.mux_a   = MUX_ALU;
                        cw.rf_fun  = FUN_LOAD;
                        cw.rf_reg  = dst_en;
                    end
                    OC_HLT:  state_d = ST_HALT;
                    default: state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_T0;
                endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

    // Reset low overrides the INIT word so nothing is cleared until release
    assign cw_o = Reset ? cw : CW_IDLE;

    assign cb.RF_OutASel  = cw_o.rf_outa;
    assign cb.RF_OutBSel  = cw_o.rf_outb;
    assign cb.RF_FunSel   = cw_o.rf_fun;
    assign cb.RF_RegSel   = cw_o.rf_reg;
    assign cb.RF_ScrSel   = cw_o.rf_scr;
    assign cb.ALU_FunSel  = cw_o.alu_fun;
    assign cb.ALU_WF      = cw_o.alu_wf;
    assign cb.ARF_OutCSel = cw_o.arf_outc;
    assign cb.ARF_OutDSel = cw_o.arf_outd;
    assign cb.ARF_FunSel  = cw_o.arf_fun;
    assign cb.ARF_RegSel  = cw_o.arf_reg;
    assign cb.IR_LH       = cw_o.ir_lh;
    assign cb.IR_Write    = cw_o.ir_write;
    assign cb.Mem_WR      = cw_o.mem_wr;
    assign cb.Mem_CS      = cw_o.mem_cs;
    assign cb.MuxASel     = cw_o.mux_a;
    assign cb.MuxBSel     = cw_o.mux_b;
    assign cb.MuxCSel     = cw_o.mux_c;
    assign cb.Halted      = Reset && (state_q == ST_HALT);
    assign cb.IllegalOp   = Reset && (state_q == ST_T2) && (oc == OC_ILL);
endmodule

// File: tb/tb_hardwired_control_sequencer.sv
module tb_hardwired_control_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hardwired_control_sequencer_if bus ();

    hardwired_control_sequencer #(.OPC_W(6), .HALT_ON_ILLEGAL(1'b0)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .cb    (bus)
    );

    always #5 Clock = ~Clock;

    // advance one cycle, settle 1ns past the edge
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // from T0: load IROut, advance through T1 into T2
    task automatic to_t2(input logic [15:0] ir);
        bus.IROut = ir;
        step();
        step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++; if (bus.RF_RegSel !== 4'b1111 || bus.Mem_CS !== 1'b1 || bus.RF_FunSel !== 3'b000) begin
            bad++; $display("FAIL reset_idle regsel=%b cs=%b fun=%b exp 1111/1/000", bus.RF_RegSel, bus.Mem_CS, bus.RF_FunSel); end
        Reset = 1'b1;
        #1;
        total++; if ({bus.RF_FunSel, bus.RF_RegSel, bus.RF_ScrSel, bus.ARF_FunSel, bus.ARF_RegSel} !== {3'b011, 4'b0000, 4'b0000, 3'b011, 3'b000}) begin
            bad++; $display("FAIL init_word rf=%b/%b/%b arf=%b/%b exp 011/0000/0000 011/000",
                bus.RF_FunSel, bus.RF_RegSel, bus.RF_ScrSel, bus.ARF_FunSel, bus.ARF_RegSel); end
        step();
        total++; if ({bus.Mem_CS, bus.IR_LH, bus.IR_Write, bus.ARF_RegSel, bus.ARF_FunSel, bus.ARF_OutDSel} !== {1'b0, 1'b0, 1'b1, 3'b011, 3'b001, 2'b00}) begin
            bad++; $display("FAIL t0_word cs=%b lh=%b irw=%b arfreg=%b arffun=%b outd=%b exp 0 0 1 011 001 00",
                bus.Mem_CS, bus.IR_LH, bus.IR_Write, bus.ARF_RegSel, bus.ARF_FunSel, bus.ARF_OutDSel); end
        total++; if (bus.RF_RegSel !== 4'b1111 || bus.RF_ScrSel !== 4'b1111) begin
            bad++; $display("FAIL t0_no_rf_write regsel=%b scrsel=%b exp 1111 1111", bus.RF_RegSel, bus.RF_ScrSel); end
        step();
        total++; if (bus.IR_LH !== 1'b1 || bus.Mem_CS !== 1'b0 || bus.IR_Write !== 1'b1) begin
            bad++; $display("FAIL t1_word lh=%b cs=%b irw=%b exp 1 0 1", bus.IR_LH, bus.Mem_CS, bus.IR_Write); end
        step(); // T2 of whatever is in IROut (a NOP-free BRA 0); return to T0
        step();
    endtask

    task automatic test_ldi();
        to_t2(16'h0A7F);
        total++; if ({bus.MuxASel, bus.RF_FunSel, bus.RF_RegSel} !== {2'b11, 3'b010, 4'b1101}) begin
            bad++; $display("FAIL ldi muxa=%b fun=%b regsel=%b exp 11 010 1101", bus.MuxASel, bus.RF_FunSel, bus.RF_RegSel); end
        step();
        total++; if (bus.IR_Write !== 1'b1 || bus.IR_LH !== 1'b0) begin
            bad++; $display("FAIL ldi_next_t0 irw=%b lh=%b exp 1 0", bus.IR_Write, bus.IR_LH); end
    endtask

    task automatic test_add();
        // ADD S=1, DST=R3 (110), SRC1=R2 (101), SRC2=R4 (111)
        to_t2(16'h1FAF);
        total++; if ({bus.ALU_FunSel, bus.ALU_WF, bus.RF_OutASel, bus.RF_OutBSel, bus.RF_RegSel, bus.MuxASel} !== {5'b10100, 1'b1, 3'b101, 3'b111, 4'b1101, 2'b00}) begin
            bad++; $display("FAIL add alu=%b wf=%b a=%b b=%b reg=%b muxa=%b exp 10100 1 101 111 1101 00",
                bus.ALU_FunSel, bus.ALU_WF, bus.RF_OutASel, bus.RF_OutBSel, bus.RF_RegSel, bus.MuxASel); end
        step();
        // MOV S=0, DST=R1, SRC1=R4: 0011 0001 0011 1100
        to_t2(16'h313C);
        total++; if ({bus.ALU_FunSel, bus.ALU_WF, bus.RF_OutASel, bus.RF_RegSel} !== {5'b10000, 1'b0, 3'b111, 4'b0111}) begin
            bad++; $display("FAIL mov alu=%b wf=%b a=%b reg=%b exp 10000 0 111 0111",
                bus.ALU_FunSel, bus.ALU_WF, bus.RF_OutASel, bus.RF_RegSel); end
        step();
    endtask

    task automatic test_bne();
        bus.FlagsOut = 4'b1000;
        to_t2(16'h0410);
        total++; if ({bus.MuxBSel, bus.ARF_RegSel, bus.RF_RegSel, bus.Mem_CS, bus.IR_Write} !== {2'b00, 3'b111, 4'b1111, 1'b1, 1'b0}) begin
            bad++; $display("FAIL bne_taken_z muxb=%b arfreg=%b reg=%b cs=%b irw=%b exp idle",
                bus.MuxBSel, bus.ARF_RegSel, bus.RF_RegSel, bus.Mem_CS, bus.IR_Write); end
        step();
        bus.FlagsOut = 4'b0000;
        to_t2(16'h0410);
        total++; if ({bus.MuxBSel, bus.ARF_RegSel, bus.ARF_FunSel} !== {2'b11, 3'b011, 3'b010}) begin
            bad++; $display("FAIL bne_branch muxb=%b arfreg=%b arffun=%b exp 11 011 010", bus.MuxBSel, bus.ARF_RegSel, bus.ARF_FunSel); end
        step();
    endtask

    task automatic test_stm();
        to_t2(16'h1000);
        total++; if ({bus.MuxCSel, bus.Mem_WR, bus.Mem_CS, bus.ARF_OutDSel, bus.ARF_RegSel, bus.ARF_FunSel, bus.ALU_FunSel, bus.RF_OutASel} !== {1'b0, 1'b1, 1'b0, 2'b10, 3'b101, 3'b001, 5'b10000, 3'b100}) begin
            bad++; $display("FAIL stm_t2 muxc=%b wr=%b cs=%b outd=%b arfreg=%b arffun=%b alu=%b a=%b",
                bus.MuxCSel, bus.Mem_WR, bus.Mem_CS, bus.ARF_OutDSel, bus.ARF_RegSel, bus.ARF_FunSel, bus.ALU_FunSel, bus.RF_OutASel); end
        step();
        total++; if ({bus.MuxCSel, bus.Mem_WR, bus.ARF_RegSel, bus.ARF_FunSel, bus.RF_RegSel} !== {1'b1, 1'b1, 3'b101, 3'b001, 4'b1111}) begin
            bad++; $display("FAIL stm_t3 muxc=%b wr=%b arfreg=%b arffun=%b reg=%b exp 1 1 101 001 1111",
                bus.MuxCSel, bus.Mem_WR, bus.ARF_RegSel, bus.ARF_FunSel, bus.RF_RegSel); end
        step();
        total++; if (bus.IR_Write !== 1'b1 || bus.IR_LH !== 1'b0 || bus.Mem_WR !== 1'b0) begin
            bad++; $display("FAIL stm_back_t0 irw=%b lh=%b wr=%b exp 1 0 0", bus.IR_Write, bus.IR_LH, bus.Mem_WR); end
    endtask

    task automatic test_illegal();
        to_t2(16'h3400); // opcode 0x0D
        total++; if (bus.IllegalOp !== 1'b1 || bus.RF_RegSel !== 4'b1111 || bus.ARF_RegSel !== 3'b111) begin
            bad++; $display("FAIL ill_opc ill=%b reg=%b arfreg=%b exp 1 1111 111", bus.IllegalOp, bus.RF_RegSel, bus.ARF_RegSel); end
        step();
        total++; if (bus.IllegalOp !== 1'b0 || bus.IR_Write !== 1'b1 || bus.Halted !== 1'b0) begin
            bad++; $display("FAIL ill_pulse ill=%b irw=%b halted=%b exp 0 1 0", bus.IllegalOp, bus.IR_Write, bus.Halted); end
        to_t2(16'h1C24); // ADD with DST = 000
        total++; if (bus.IllegalOp !== 1'b1 || bus.RF_RegSel !== 4'b1111) begin
            bad++; $display("FAIL ill_fmtb ill=%b reg=%b exp 1 1111", bus.IllegalOp, bus.RF_RegSel); end
        step();
    endtask

    task automatic test_ldm_reset();
        to_t2(16'h0C00); // LDM R1
        total++; if ({bus.RF_FunSel, bus.MuxASel, bus.ARF_OutDSel, bus.RF_RegSel, bus.ARF_RegSel, bus.Mem_CS} !== {3'b101, 2'b10, 2'b10, 4'b0111, 3'b101, 1'b0}) begin
            bad++; $display("FAIL ldm_t2 fun=%b muxa=%b outd=%b reg=%b arfreg=%b cs=%b",
                bus.RF_FunSel, bus.MuxASel, bus.ARF_OutDSel, bus.RF_RegSel, bus.ARF_RegSel, bus.Mem_CS); end
        step();
        total++; if (bus.RF_FunSel !== 3'b110 || bus.ARF_RegSel !== 3'b101) begin
            bad++; $display("FAIL ldm_t3 fun=%b arfreg=%b exp 110 101", bus.RF_FunSel, bus.ARF_RegSel); end
        #2 Reset = 1'b0;
        #1;
        total++; if ({bus.RF_FunSel, bus.RF_RegSel, bus.ARF_RegSel, bus.Mem_CS} !== {3'b000, 4'b1111, 3'b111, 1'b1}) begin
            bad++; $display("FAIL midreset_idle fun=%b reg=%b arfreg=%b cs=%b exp 000 1111 111 1",
                bus.RF_FunSel, bus.RF_RegSel, bus.ARF_RegSel, bus.Mem_CS); end
        step();
        Reset = 1'b1;
        #1;
        total++; if (bus.RF_FunSel !== 3'b011 || bus.RF_RegSel !== 4'b0000 || bus.ARF_RegSel !== 3'b000) begin
            bad++; $display("FAIL reinit fun=%b reg=%b arfreg=%b exp 011 0000 000", bus.RF_FunSel, bus.RF_RegSel, bus.ARF_RegSel); end
        step();
        total++; if (bus.IR_Write !== 1'b1 || bus.IR_LH !== 1'b0 || bus.ARF_RegSel !== 3'b011) begin
            bad++; $display("FAIL refetch irw=%b lh=%b arfreg=%b exp 1 0 011", bus.IR_Write, bus.IR_LH, bus.ARF_RegSel); end
    endtask

    task automatic test_halt();
        to_t2(16'hFC00);
        total++; if (bus.RF_RegSel !== 4'b1111 || bus.Mem_CS !== 1'b1 || bus.IllegalOp !== 1'b0) begin
            bad++; $display("FAIL hlt_t2 reg=%b cs=%b ill=%b exp 1111 1 0", bus.RF_RegSel, bus.Mem_CS, bus.IllegalOp); end
        step();
        total++; if (bus.Halted !== 1'b1) begin
            bad++; $display("FAIL halted got=%b exp 1", bus.Halted); end
        bus.IROut = 16'h0A7F;
        repeat (4) step();
        total++; if (bus.Halted !== 1'b1 || bus.IR_Write !== 1'b0 || bus.RF_RegSel !== 4'b1111 || bus.Mem_CS !== 1'b1) begin
            bad++; $display("FAIL halt_stays halted=%b irw=%b reg=%b cs=%b exp 1 0 1111 1",
                bus.Halted, bus.IR_Write, bus.RF_RegSel, bus.Mem_CS); end
    endtask

    initial begin
        bus.IROut    = 16'h0000;
        bus.FlagsOut = 4'b0000;
        test_reset();
        test_ldi();
        test_add();
        test_bne();
        test_stm();
        test_illegal();
        test_ldm_reset();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
